// File: rtl/mmc1_pkg.sv
// rtl/mmc1_pkg.sv - shared constants, state type and bus-field helper for the MMC1 serial writer
package mmc1_pkg;

  localparam logic [1:0] MMC1_REG_CTRL = 2'd0;
  localparam logic [1:0] MMC1_REG_CHR0 = 2'd1;
  localparam logic [1:0] MMC1_REG_CHR1 = 2'd2;
  localparam logic [1:0] MMC1_REG_PRG  = 2'd3;

  localparam int MMC1_SHIFT_BITS = 5;

  typedef enum logic [1:0] {IDLE, ARM, WRITE, GAP} mmc1_state_t;

  // A gap of zero would let the mapper see writes on adjacent M2 cycles, so clamp to 1
  function automatic int gap_eff(input int gap_cycles);
    return (gap_cycles < 1) ? 1 : gap_cycles;
  endfunction

  // {A14, A13, D0, D7} for a write cycle: reset writes target $8000 with D7 set
  function automatic logic [3:0] write_fields(input logic reset_wr, input logic [1:0] sel,
                                              input logic bit0);
    return reset_wr ? {MMC1_REG_CTRL, 1'b0, 1'b1} : {sel, bit0, 1'b0};
  endfunction

endpackage

// File: rtl/mmc1_serial_writer_if.sv
// rtl/mmc1_serial_writer_if.sv - host command handshake and CPU bus signals of the MMC1 serial writer
interface mmc1_serial_writer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_reg;
  logic [4:0] cmd_data;
  logic       cmd_rst;
  logic       done;

  logic M2;
  logic nROMSEL;
  logic CPU_RnW;
  logic CPU_A14;
  logic CPU_A13;
  logic CPU_D0;
  logic CPU_D7;

  modport master (
    output cmd_valid, cmd_reg, cmd_data, cmd_rst,
    input  cmd_ready, done,
    input  M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7
  );

  modport slave (
    input  cmd_valid, cmd_reg, cmd_data, cmd_rst,
    output cmd_ready, done,
    output M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7
  );

endinterface

// File: rtl/mmc1_m2_gen.sv
// rtl/mmc1_m2_gen.sv - free-running M2 phase generator with bus-cycle boundary and M2-rise strobes
module mmc1_m2_gen #(
  parameter int M2_LO = 3,
  parameter int M2_HI = 3
) (
  input  logic clk,
  input  logic rst,
  output logic m2,
  output logic boundary,
  output logic m2_rise
);

  localparam int PERIOD = M2_LO + M2_HI;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase;

  // Strobes flag the edge on which phase wraps to 0 / M2 goes high
  assign boundary = (phase == PW'(PERIOD - 1));
  assign m2_rise  = (phase == PW'(M2_LO - 1));

  // Phase counter and registered M2 (high while phase >= M2_LO)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      m2    <= 1'b0;
    end else begin
      if (boundary) phase <= '0;
      else          phase <= phase + 1'b1;
      if (m2_rise)       m2 <= 1'b1;
      else if (boundary) m2 <= 1'b0;
    end
  end

endmodule

// File: rtl/mmc1_serial_writer.sv
// rtl/mmc1_serial_writer.sv - MMC1 five-write serial loader; MMC1_WR_AUTORESET_EN prefixes loads with a reset write
module mmc1_serial_writer
  import mmc1_pkg::*;
#(
  parameter int M2_LO      = 3,
  parameter int M2_HI      = 3,
  parameter int GAP_CYCLES = 1
) (
  input logic CLK,
  input logic RES,
  mmc1_serial_writer_if.slave bus
);

  localparam int GAP_EFF = gap_eff(GAP_CYCLES);

  logic m2, boundary, m2_rise;

  mmc1_state_t state;
  logic [4:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic [1:0]  sel;
  logic        is_rst;
  logic        reset_wr;
  logic        ready, done;
  logic        rnw, a14, a13, d0, d7;
  logic        nromsel;

  mmc1_m2_gen #(.M2_LO(M2_LO), .M2_HI(M2_HI)) u_m2_gen (
    .clk      (CLK),
    .rst      (RES),
    .m2       (m2),
    .boundary (boundary),
    .m2_rise  (m2_rise)
  );

  assign bus.cmd_ready = ready;
  assign bus.done      = done;
  assign bus.M2        = m2;
  assign bus.nROMSEL   = nromsel;
  assign bus.CPU_RnW   = rnw;
  assign bus.CPU_A14   = a14;
  assign bus.CPU_A13   = a13;
  assign bus.CPU_D0    = d0;
  assign bus.CPU_D7    = d7;

  // ROM select follows M2 high, but only inside a write cycle
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                  nromsel <= 1'b1;
    else if (boundary)        nromsel <= 1'b1;
    else if (m2_rise && !rnw) nromsel <= 1'b0;
  end

  // Command FSM: bus fields only move on cycle boundaries, writes are always followed by a gap
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      sel      <= '0;
      is_rst   <= 1'b0;
      reset_wr <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rnw      <= 1'b1;
      a14      <= 1'b0;
      a13      <= 1'b0;
      d0       <= 1'b0;
      d7       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && ready) begin
            ready   <= 1'b0;
            sel     <= bus.cmd_reg;
            shift   <= bus.cmd_data;
            is_rst  <= bus.cmd_rst;
            bit_cnt <= '0;
`ifdef MMC1_WR_AUTORESET_EN
            reset_wr <= 1'b1;
`else
            reset_wr <= bus.cmd_rst;
`endif
            state <= ARM;
          end
        end
        ARM: begin
          if (boundary) begin
            rnw                <= 1'b0;
            {a14, a13, d0, d7} <= write_fields(reset_wr, sel, shift[0]);
            state              <= WRITE;
          end
        end
        WRITE: begin
          if (boundary) begin
            rnw                <= 1'b1;
            {a14, a13, d0, d7} <= 4'b0000;
            gap_cnt            <= '0;
            if (reset_wr) begin
              reset_wr <= 1'b0;
              if (is_rst) bit_cnt <= 3'(MMC1_SHIFT_BITS);
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[4:1]};
            end
            state <= GAP;
          end
        end
        GAP: begin
          if (boundary) begin
            if (gap_cnt == 16'(GAP_EFF - 1)) begin
              if (bit_cnt < 3'(MMC1_SHIFT_BITS)) begin
                rnw                <= 1'b0;
                {a14, a13, d0, d7} <= write_fields(reset_wr, sel, shift[0]);
                state              <= WRITE;
              end else begin
                done  <= 1'b1;
                ready <= 1'b1;
                state <= IDLE;
              end
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmc1_serial_writer.md
Name: mmc1_serial_writer

Overview:
CPU-side initiator for the MMC1 five-write serial register protocol, built as a bench driver and as a host-side loader for cartridge test rigs. It takes a register select plus a 5-bit value, or a shift-register reset request. It then drives a CPU-bus cycle stream (M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D0, CPU_D7) that an MMC1 latches correctly. The driver honours the mapper's rule that it ignores writes on consecutive M2 cycles.

Parameters:
M2_LO, 3, clocks per bus cycle with M2 low (>=1)
M2_HI, 3, clocks per bus cycle with M2 high (>=1)
GAP_CYCLES, 1, idle bus cycles after every write (>=1; 0 is illegal and is treated as 1)

Ports:
CLK  in  1  system clock
RES  in  1  reset, asynchronous, active-high
cmd_valid  in  1  host command request
cmd_ready  out  1  block idle and able to accept a command
cmd_reg  in  2  register select: 0=$8000 ctrl, 1=$A000 CHR0, 2=$C000 CHR1, 3=$E000 PRG
cmd_data  in  5  value to load, LSB shifted first
cmd_rst  in  1  issue a single shift-register reset write instead of a load
done  out  1  one-clock pulse when the command's last bus cycle completes
M2  out  1  CPU M2 phase clock, free-running after reset
nROMSEL  out  1  active-low $8000-$FFFF select
CPU_RnW  out  1  1=read/idle, 0=write
CPU_A14  out  1  address bit 14
CPU_A13  out  1  address bit 13
CPU_D0  out  1  serial data bit
CPU_D7  out  1  reset-request bit

Behaviour:
- Reset values: M2=0, nROMSEL=1, CPU_RnW=1, CPU_A14=0, CPU_A13=0, CPU_D0=0, CPU_D7=0, cmd_ready=1, done=0, state IDLE, phase and bit counters 0.
- Phase counter runs 0..M2_LO+M2_HI-1 continuously and wraps; M2=1 when phase>=M2_LO.
- A cycle boundary is the wrap to phase 0. Bus fields (RnW, A14/A13, D0, D7) change only at boundaries and hold for the whole bus cycle.
- nROMSEL = 0 only while M2=1 in a write cycle. In idle cycles it stays 1 (RAM-space read) with RnW=1.
- Handshake: accepted on the CLK edge with cmd_valid & cmd_ready. cmd_ready drops the same edge. cmd_reg, cmd_data and cmd_rst are captured then, and later input changes are ignored.
- States:
  - IDLE: on accept -> ARM.
  - ARM: wait for the next boundary -> WRITE.
  - WRITE: one bus cycle with RnW=0, A14:A13=cmd_reg, D0=shift[0], D7=0. At its end, bit counter +1 and shift right -> GAP.
  - GAP: GAP_CYCLES idle cycles. Then, if bit count < 5 -> WRITE; else -> IDLE, with done=1 for one clock and cmd_ready=1 on the same edge.
- Reset command: a single WRITE with D7=1, D0=0, A14:A13=00, followed by GAP. Bit count is forced to 5.
- Data load: 5 writes and 5 GAP spans, total 5*(1+GAP_CYCLES) bus cycles after ARM.
- Invariants:
  - Two consecutive bus cycles never both have RnW=0.
  - Bus fields never change while M2=1.
- cmd_valid while busy is held off, never dropped.
- Async RES mid-command: outputs take reset values immediately and the command is abandoned without a done pulse. The mapper's partial shift state is the host's responsibility; the host clears it with a cmd_rst command.

Optional Feature:
- MMC1_WR_AUTORESET_EN defined: every load command (cmd_rst=0) is prefixed with a reset write (D7=1, addr $8000) and its GAP. Total is 6*(1+GAP_CYCLES) cycles, and done fires only after the fifth data write's gap.
- Undefined: loads issue exactly 5 writes. cmd_rst behaviour is identical in both builds.

Decomposition:
- Shared package mmc1_pkg holds:
  - register-select constants (MMC1_REG_CTRL=0, MMC1_REG_CHR0=1, MMC1_REG_CHR1=2, MMC1_REG_PRG=3);
  - the state enum (IDLE, ARM, WRITE, GAP);
  - MMC1_SHIFT_BITS=5.
- One natural sub-module, mmc1_m2_gen, owns the phase counter and emits M2, a boundary strobe and an m2_rise strobe. The FSM and shift logic stay in the top.

Test Plan (M2_LO=2, M2_HI=2, GAP_CYCLES=1 unless stated):
- cmd_reg=3, cmd_data=5'b10110 -> five write cycles with D0=0,1,1,0,1, A14=1, A13=1, D7=0, each followed by one idle cycle. done arrives 10 bus cycles after the first write's boundary.
- cmd_rst=1 -> exactly one write with D7=1, D0=0, A14:A13=00, then one idle cycle, then done. No further writes.
- GAP_CYCLES=0 build -> behaves as GAP_CYCLES=1. Monitor confirms no two adjacent cycles have RnW=0 across all tests.
- Async RES asserted during the 3rd write while M2=1 -> M2=0, nROMSEL=1, RnW=1 the same clock. No done pulse. cmd_ready=1 after RES deasserts.
- Back-to-back commands with cmd_valid held high -> second accept occurs on the done clock. Bus fields are stable through every M2-high window.
- MMC1_WR_AUTORESET_EN, cmd_reg=0, cmd_data=5'h0C -> 6 writes: reset first, then D0=0,0,1,1,0. done after 12 bus cycles.
